// File: rtl/reg_exec_sequencer.sv
// Four-state execute controller wrapped around register_bank: issues the operand
// reads, runs one ALU operation on the returned lines and drives the write-back port.
module reg_exec_sequencer #(
   parameter  int DATA_W  = 16,
   parameter  int ADDR_W  = 5,
   localparam int INSTR_W = 4 + 3*ADDR_W + 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               read_1EN,
   output logic               read_2EN,
   output logic [ADDR_W-1:0]  read_1,
   output logic [ADDR_W-1:0]  read_2,
   input  logic [DATA_W-1:0]  line_a,
   input  logic [DATA_W-1:0]  line_b,
   output logic               writeEN,
   output logic [ADDR_W-1:0]  write_reg_address,
   output logic [DATA_W-1:0]  write_val,
   output logic               done,
   output logic               err,
   output logic               zero,
   output logic               carry,
   output logic [1:0]         o_dbg_state
);

   // Handshake: an instruction transfers on a rising edge where instr_valid and
   // instr_ready are both high; instr_ready is high only in IDLE, so instr_valid
   // and instr are don't-care while an instruction is in flight.

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_NOP  = 4'd15;

   state_t              r_state;
   logic [3:0]          r_op;
   logic [ADDR_W-1:0]   r_rd;
   logic [4:0]          r_imm;
   logic                r_instr_ready;
   logic                r_read_en;
   logic [ADDR_W-1:0]   r_read_1;
   logic [ADDR_W-1:0]   r_read_2;
   logic                r_write_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_val;
   logic                r_done;
   logic                r_err;
   logic                r_zero;
   logic                r_carry;

   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_result;
   logic                w_carry;
   logic                w_write;
   logic                w_illegal;
   logic [3:0]          w_shamt;
   logic [2*DATA_W-1:0] w_shl;
   logic [2*DATA_W-1:0] w_shr;

   assign w_shamt = r_imm[3:0];
   // Widened shifts leave the last bit shifted out just beyond the result field.
   assign w_shl   = {{DATA_W{1'b0}}, line_a} << w_shamt;
   assign w_shr   = {line_a, {DATA_W{1'b0}}} >> w_shamt;

   always_comb begin
      w_sum     = '0;
      w_carry   = 1'b0;
      w_write   = 1'b1;
      w_illegal = 1'b0;
      case (r_op)
         OP_ADD:  begin
            w_sum   = {1'b0, line_a} + {1'b0, line_b};
            w_carry = w_sum[DATA_W];
         end
         OP_SUB:  begin
            w_sum   = {1'b0, line_a} - {1'b0, line_b};
            w_carry = (line_a < line_b);
         end
         OP_AND:  w_sum = {1'b0, line_a & line_b};
         OP_OR:   w_sum = {1'b0, line_a | line_b};
         OP_XOR:  w_sum = {1'b0, line_a ^ line_b};
         OP_SHL:  begin
            w_sum   = {1'b0, w_shl[DATA_W-1:0]};
            w_carry = w_shl[DATA_W];
         end
         OP_SHR:  begin
            w_sum   = {1'b0, w_shr[2*DATA_W-1:DATA_W]};
            w_carry = w_shr[DATA_W-1];
         end
         OP_MOV:  w_sum = {1'b0, line_a};
         OP_ADDI: begin
            w_sum   = {1'b0, line_a} + {{(DATA_W-4){1'b0}}, r_imm};
            w_carry = w_sum[DATA_W];
         end
         OP_NOP:  w_write = 1'b0;
         default: begin
            w_write   = 1'b0;
            w_illegal = 1'b1;
         end
      endcase
   end

   assign w_result = w_sum[DATA_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_op          <= '0;
         r_rd          <= '0;
         r_imm         <= '0;
         r_instr_ready <= 1'b1;
         r_read_en     <= 1'b0;
         r_read_1      <= '0;
         r_read_2      <= '0;
         r_write_en    <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_val      <= '0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_zero        <= 1'b0;
         r_carry       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_op          <= instr[INSTR_W-1 -: 4];
                  r_rd          <= instr[3*ADDR_W+4 -: ADDR_W];
                  r_imm         <= instr[4:0];
                  r_read_1      <= instr[2*ADDR_W+4 -: ADDR_W];
                  r_read_2      <= instr[ADDR_W+4 -: ADDR_W];
                  r_read_en     <= 1'b1;
                  r_instr_ready <= 1'b0;
                  r_state       <= S_READ;
               end
            end
            S_READ: begin
               r_read_en <= 1'b0;
               r_state   <= S_EXEC;
            end
            S_EXEC: begin
               // Bank data arrived on the edge closing READ and is stable now.
               r_done <= 1'b1;
               r_err  <= w_illegal;
               if (w_write) begin
                  r_write_en <= 1'b1;
                  r_wr_addr  <= r_rd;
                  r_wr_val   <= w_result;
                  r_zero     <= (w_result == '0);
                  r_carry    <= w_carry;
               end
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_write_en    <= 1'b0;
               r_done        <= 1'b0;
               r_err         <= 1'b0;
               r_instr_ready <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign instr_ready       = r_instr_ready;
   assign read_1EN          = r_read_en;
   assign read_2EN          = r_read_en;
   assign read_1            = r_read_1;
   assign read_2            = r_read_2;
   assign writeEN           = r_write_en;
   assign write_reg_address = r_wr_addr;
   assign write_val         = r_wr_val;
   assign done              = r_done;
   assign err               = r_err;
   assign zero              = r_zero;
   assign carry             = r_carry;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_reg_exec_sequencer.sv
// Directed bench for reg_exec_sequencer with a behavioural register_bank and a
// write-back scoreboard.
module tb_reg_exec_sequencer;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [23:0] instr;
   logic        read_1EN, read_2EN;
   logic [4:0]  read_1, read_2;
   logic [15:0] line_a, line_b;
   logic        writeEN;
   logic [4:0]  write_reg_address;
   logic [15:0] write_val;
   logic        done, err, zero, carry;
   logic [1:0]  o_dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [20:0] exp_q[$];

   logic [15:0] mem[32];
   logic        poke_en;
   logic [4:0]  poke_addr;
   logic [15:0] poke_val;

   reg_exec_sequencer dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .read_1EN(read_1EN), .read_2EN(read_2EN), .read_1(read_1),
      .read_2(read_2), .line_a(line_a), .line_b(line_b), .writeEN(writeEN),
      .write_reg_address(write_reg_address), .write_val(write_val), .done(done),
      .err(err), .zero(zero), .carry(carry), .o_dbg_state(o_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // register_bank model: synchronous read, line valid after the enabled cycle
   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_val;
      else if (writeEN) mem[write_reg_address] <= write_val;
      if (read_1EN) line_a <= mem[read_1];
      if (read_2EN) line_b <= mem[read_2];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every write-back must match the next expected {rd, value}
   always @(negedge clk) begin
      if (reset && writeEN) begin
         if (exp_q.size() == 0) chk("sb_unexpected_write", {11'd0, write_reg_address, write_val}, 32'd0);
         else chk("sb_write", {11'd0, write_reg_address, write_val}, {11'd0, exp_q.pop_front()});
      end
   end

   // driver tasks
   task automatic poke(input logic [4:0] a, input logic [15:0] v);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_val = v;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] imm,
                         input logic exp_we, input logic [15:0] exp_val,
                         input logic exp_err, input logic exp_z, input logic exp_c);
      @(negedge clk);
      chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      instr = {op, rd, rs1, rs2, imm};
      if (exp_we) exp_q.push_back({rd, exp_val});
      @(posedge clk); #1;
      // keep valid high with junk to show it is ignored while busy
      instr = 24'($urandom);
      chk({tag, "_read_en"}, {30'd0, read_1EN, read_2EN}, 32'd3);
      chk({tag, "_read_addr"}, {22'd0, read_1, read_2}, {22'd0, rs1, rs2});
      chk({tag, "_busy"}, {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_exec"}, {28'd0, o_dbg_state, read_1EN, done}, {28'd0, 2'd2, 1'b0, 1'b0});
      @(posedge clk); #1;
      chk({tag, "_done_err_we"}, {29'd0, done, err, writeEN}, {29'd0, 1'b1, exp_err, exp_we});
      if (exp_we)
         chk({tag, "_wb"}, {11'd0, write_reg_address, write_val}, {11'd0, rd, exp_val});
      chk({tag, "_flags"}, {30'd0, zero, carry}, {30'd0, exp_z, exp_c});
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk({tag, "_retire"}, {28'd0, instr_ready, done, err, writeEN}, {28'd0, 4'b1000});
   endtask

   initial begin
      reset = 1'b0; instr_valid = 1'b1; instr = {4'd0, 5'd1, 5'd2, 5'd3, 5'd0};
      poke_en = 1'b0; poke_addr = '0; poke_val = '0;
      line_a = '0; line_b = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {24'd0, instr_ready, writeEN, read_1EN, read_2EN, done, err, zero, carry},
          {24'd0, 8'b1000_0000});
      chk("reset_state", {30'd0, o_dbg_state}, 32'd0);
      @(negedge clk);
      instr_valid = 1'b0;
      reset = 1'b1;

      poke(5'd3, 16'd10);
      poke(5'd4, 16'd20);
      run_op("add",      4'd0,  5'd15, 5'd3, 5'd4, 5'd0, 1'b1, 16'd30,     1'b0, 1'b0, 1'b0);
      run_op("sub_brw",  4'd1,  5'd5,  5'd3, 5'd4, 5'd0, 1'b1, 16'hFFF6,   1'b0, 1'b0, 1'b1);
      run_op("sub_zero", 4'd1,  5'd6,  5'd3, 5'd3, 5'd0, 1'b1, 16'h0000,   1'b0, 1'b1, 1'b0);
      poke(5'd3, 16'h8001);
      run_op("shl1",     4'd5,  5'd7,  5'd3, 5'd0, 5'd1, 1'b1, 16'h0002,   1'b0, 1'b0, 1'b1);
      run_op("shr1",     4'd6,  5'd8,  5'd3, 5'd0, 5'd1, 1'b1, 16'h4000,   1'b0, 1'b0, 1'b1);
      poke(5'd3, 16'hFFFF);
      run_op("addi",     4'd8,  5'd9,  5'd3, 5'd0, 5'd1, 1'b1, 16'h0000,   1'b0, 1'b1, 1'b1);
      run_op("illegal",  4'd9,  5'd10, 5'd3, 5'd4, 5'd0, 1'b0, 16'h0000,   1'b1, 1'b1, 1'b1);
      run_op("nop",      4'd15, 5'd10, 5'd3, 5'd4, 5'd0, 1'b0, 16'h0000,   1'b0, 1'b1, 1'b1);
      run_op("shl0",     4'd5,  5'd11, 5'd3, 5'd0, 5'h10, 1'b1, 16'hFFFF,  1'b0, 1'b0, 1'b0);
      poke(5'd10, 16'hF0F0);
      poke(5'd11, 16'h0FF0);
      run_op("and",      4'd2,  5'd12, 5'd10, 5'd11, 5'd0, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0);
      run_op("or",       4'd3,  5'd12, 5'd10, 5'd11, 5'd0, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0);
      run_op("xor",      4'd4,  5'd12, 5'd10, 5'd11, 5'd0, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0);
      run_op("mov_r0",   4'd7,  5'd0,  5'd3, 5'd0, 5'd0, 1'b1, 16'hFFFF,   1'b0, 1'b0, 1'b0);
      poke(5'd12, 16'h0001);
      run_op("add_ovf",  4'd0,  5'd13, 5'd3, 5'd12, 5'd0, 1'b1, 16'h0000,  1'b0, 1'b1, 1'b1);
      chk("bank_r0", {16'd0, mem[0]}, 32'h0000FFFF);

      // abort an ADD during EXEC: nothing may be written back
      poke(5'd3, 16'd10);
      poke(5'd15, 16'd0);
      @(negedge clk);
      instr_valid = 1'b1;
      instr = {4'd0, 5'd15, 5'd3, 5'd4, 5'd0};
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_exec", {30'd0, o_dbg_state}, 32'd2);
      reset = 1'b0;
      #1;
      chk("abort_reset", {27'd0, instr_ready, writeEN, done, zero, carry}, {27'd0, 5'b10000});
      chk("abort_state", {30'd0, o_dbg_state}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_write", {31'd0, writeEN}, 32'd0);
      end
      chk("abort_bank_r15", {16'd0, mem[15]}, 32'd0);
      run_op("add_after", 4'd0, 5'd15, 5'd3, 5'd4, 5'd0, 1'b1, 16'd30, 1'b0, 1'b0, 1'b0);
      run_op("mov_back",  4'd7, 5'd1,  5'd15, 5'd0, 5'd0, 1'b1, 16'd30, 1'b0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
